// File: rtl/div_unit.sv
// ============================================================================
// div_unit : multi-cycle radix-2 restoring divider, result = {HI=rem, LO=quo}
// Rev 1.0
// ============================================================================
`default_nettype none

module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  signed_i,
    input  logic                  annul_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  busy_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     rem_q, rem_d;
    logic [DATA_W-1:0]     quo_q, quo_d;
    logic [DATA_W-1:0]     dvsr_q, dvsr_d;
    logic                  sign1_q, sign1_d;
    logic                  sign2_q, sign2_d;
    logic                  signed_q, signed_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;

    logic [DATA_W:0]       w_trial;
    logic [DATA_W-1:0]     w_rem_step;
    logic [DATA_W-1:0]     w_quo_step;
    logic                  w_neg1;
    logic                  w_neg2;

    // Shift the {rem, quo} pair left and try to subtract the divisor from the new rem.
    assign w_trial    = {rem_q, quo_q[DATA_W-1]} - {1'b0, dvsr_q};
    assign w_rem_step = w_trial[DATA_W] ? {rem_q[DATA_W-2:0], quo_q[DATA_W-1]}
                                        : w_trial[DATA_W-1:0];
    assign w_quo_step = {quo_q[DATA_W-2:0], ~w_trial[DATA_W]};

    assign w_neg1 = signed_i & opdata1_i[DATA_W-1];
    assign w_neg2 = signed_i & opdata2_i[DATA_W-1];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        signed_d = signed_q;
        result_d = result_q;
        ready_d  = 1'b0;

        case (state_q)
            FREE: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d  = ON;
                        quo_d    = w_neg1 ? -opdata1_i : opdata1_i;
                        dvsr_d   = w_neg2 ? -opdata2_i : opdata2_i;
                        rem_d    = '0;
                        cnt_d    = '0;
                        sign1_d  = opdata1_i[DATA_W-1];
                        sign2_d  = opdata2_i[DATA_W-1];
                        signed_d = signed_i;
                    end
                end
            end
            BYZERO: begin
                state_d  = FINISH;
                result_d = '0;
            end
            ON: begin
                if (annul_i) begin
                    state_d = FREE;
                end else begin
                    rem_d = w_rem_step;
                    quo_d = w_quo_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == C_LAST) begin
                        state_d  = FINISH;
                        // Remainder follows the dividend's sign; quotient the sign product.
                        result_d = {(signed_q && sign1_q) ? -w_rem_step : w_rem_step,
                                    (signed_q && (sign1_q ^ sign2_q)) ? -w_quo_step : w_quo_step};
                    end
                end
            end
            FINISH: begin
                if (!start_i || annul_i) begin
                    state_d = FREE;
                end else begin
                    ready_d = 1'b1;
                end
            end
            default: state_d = FREE;
        endcase

        busy_d = (state_d == BYZERO) || (state_d == ON);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FREE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            signed_q <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            signed_q <= signed_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign busy_o   = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// tb_div_unit : directed self-checking bench for div_unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic        annul_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int n_tests;
    int n_fail;

    div_unit #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .signed_i  (signed_i),
        .annul_i   (annul_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .busy_o    (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one operation and counts edges after E0 until ready_o is first seen (capped at 60).
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output logic [63:0] res, output int lat);
        @(negedge clk);
        signed_i  = s;
        opdata1_i = a;
        opdata2_i = b;
        start_i   = 1'b1;
        @(posedge clk);
        #2;
        opdata1_i = 32'hA5A5_5A5A;
        opdata2_i = 32'h0000_0000;
        lat = 0;
        while (lat < 60) begin
            @(posedge clk);
            lat++;
            #1;
            if (ready_o) break;
        end
        res = result_o;
    endtask

    task automatic drop_start();
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_tests++; if (result_o !== 64'h0) begin $display("FAIL reset_result got=%h exp=0", result_o); n_fail++; end
        n_tests++; if (ready_o !== 1'b0) begin $display("FAIL reset_ready got=%b exp=0", ready_o); n_fail++; end
        n_tests++; if (busy_o !== 1'b0) begin $display("FAIL reset_busy got=%b exp=0", busy_o); n_fail++; end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_unsigned();
        logic [63:0] res;
        int lat;
        run_div(32'd100, 32'd7, 1'b0, res, lat);
        n_tests++; if (lat !== 33) begin $display("FAIL t1_latency got=%0d exp=33", lat); n_fail++; end
        n_tests++; if (res !== 64'h00000002_0000000E) begin $display("FAIL t1_result got=%h exp=00000002_0000000e", res); n_fail++; end
        // start held high in END must not restart the divider
        repeat (5) @(posedge clk);
        #1;
        n_tests++; if ({ready_o, busy_o} !== 2'b10) begin $display("FAIL hold_in_end ready/busy got=%b%b exp=10", ready_o, busy_o); n_fail++; end
        drop_start();
        n_tests++; if (ready_o !== 1'b0) begin $display("FAIL ready_falls got=%b exp=0", ready_o); n_fail++; end
        n_tests++; if (result_o !== 64'h00000002_0000000E) begin $display("FAIL result_held got=%h exp=00000002_0000000e", result_o); n_fail++; end
    endtask

    task automatic test_signed();
        logic [63:0] res;
        int lat;
        run_div(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, res, lat);
        n_tests++; if (lat !== 33) begin $display("FAIL t2_latency got=%0d exp=33", lat); n_fail++; end
        n_tests++; if (res !== 64'hFFFFFFFF_FFFFFFFD) begin $display("FAIL t2_result got=%h exp=ffffffff_fffffffd", res); n_fail++; end
        drop_start();
    endtask

    task automatic test_div_zero();
        @(negedge clk);
        signed_i  = 1'b0;
        opdata1_i = 32'h0000_1234;
        opdata2_i = 32'h0;
        start_i   = 1'b1;
        @(posedge clk);
        #1;
        n_tests++; if (busy_o !== 1'b1) begin $display("FAIL t3_busy_e0 got=%b exp=1", busy_o); n_fail++; end
        @(posedge clk);
        #1;
        n_tests++; if ({busy_o, ready_o} !== 2'b00) begin $display("FAIL t3_e1 busy/ready got=%b%b exp=00", busy_o, ready_o); n_fail++; end
        @(posedge clk);
        #1;
        n_tests++; if (ready_o !== 1'b1) begin $display("FAIL t3_ready_e2 got=%b exp=1", ready_o); n_fail++; end
        n_tests++; if (result_o !== 64'h0) begin $display("FAIL t3_result got=%h exp=0", result_o); n_fail++; end
        drop_start();
    endtask

    task automatic test_annul();
        logic [63:0] res;
        int lat;
        bit  saw_ready;
        @(negedge clk);
        signed_i  = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b0;
        @(posedge clk);
        #1;
        n_tests++; if (busy_o !== 1'b0) begin $display("FAIL t4_busy_after_annul got=%b exp=0", busy_o); n_fail++; end
        saw_ready = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) saw_ready = 1'b1;
        end
        n_tests++; if (saw_ready !== 1'b0) begin $display("FAIL t4_ready_after_annul got=%b exp=0", saw_ready); n_fail++; end
        n_tests++; if (result_o !== 64'h0) begin $display("FAIL t4_result_unchanged got=%h exp=0", result_o); n_fail++; end
        run_div(32'd9, 32'd3, 1'b0, res, lat);
        n_tests++; if (lat !== 33) begin $display("FAIL t4_latency got=%0d exp=33", lat); n_fail++; end
        n_tests++; if (res !== 64'h00000000_00000003) begin $display("FAIL t4_result got=%h exp=00000000_00000003", res); n_fail++; end
        drop_start();
    endtask

    task automatic test_start_annul_free();
        @(negedge clk);
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        start_i   = 1'b1;
        annul_i   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if ({busy_o, ready_o} !== 2'b00) begin $display("FAIL start_annul_free busy/ready got=%b%b exp=00", busy_o, ready_o); n_fail++; end
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;
    endtask

    task automatic test_overflow();
        logic [63:0] res;
        int lat;
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, res, lat);
        n_tests++; if (res !== 64'h00000000_80000000) begin $display("FAIL t5_result got=%h exp=00000000_80000000", res); n_fail++; end
        drop_start();
    endtask

    task automatic test_reset_mid();
        logic [63:0] res;
        int lat;
        @(negedge clk);
        signed_i  = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        @(posedge clk);
        repeat (19) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_tests++; if ({result_o, ready_o, busy_o} !== 66'h0) begin $display("FAIL t6_async_reset result=%h ready=%b busy=%b exp all 0", result_o, ready_o, busy_o); n_fail++; end
        @(negedge clk);
        rst     = 1'b0;
        start_i = 1'b0;
        run_div(32'hFFFF_FFFF, 32'h0000_0010, 1'b0, res, lat);
        n_tests++; if (lat !== 33) begin $display("FAIL t6_latency got=%0d exp=33", lat); n_fail++; end
        n_tests++; if (res !== 64'h0000000F_0FFFFFFF) begin $display("FAIL t6_result got=%h exp=0000000f_0fffffff", res); n_fail++; end
        drop_start();
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        start_i   = 1'b0;
        signed_i  = 1'b0;
        annul_i   = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_annul();
        test_start_annul_free();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
